vga_gen: RTL and testbench
==========================

Name: vga_gen

Overview:
Parametrised successor of the fixed-mode VGA timing generator. Produces HS/VS/BLANK/RGB on video_if from fully configurable timing, with selectable sync polarity and four runtime pixel sources: grid pattern, colour bars, solid colour, and an external pixel stream with a ready/valid handshake. It sits between the pixel-clock domain source (pattern logic or a framebuffer read FIFO) and the display pins.

Parameters:
HDISP, 800, active pixels per line
VDISP, 480, active lines per frame
HFP, 40, horizontal front porch (pixels)
HPULSE, 48, HS pulse width (pixels)
HBP, 40, horizontal back porch (pixels)
VFP, 13, vertical front porch (lines)
VPULSE, 3, VS pulse width (lines)
VBP, 29, vertical back porch (lines)
HS_POL, 0, HS active level (0 = active low)
VS_POL, 0, VS active level (0 = active low)
GRID, 16, grid pitch in pixels; must be a power of two

Ports:
pixel_clk  in  1  pixel clock
pixel_rst  in  1  reset, asynchronous, active-high
mode  in  2  0 grid, 1 colour bars, 2 external stream, 3 solid colour
solid_rgb  in  24  colour used in mode 3
pix_data  in  24  external pixel, {R,G,B}
pix_valid  in  1  pix_data valid
pix_ready  out  1  block consumes pix_data this cycle
frame_start  out  1  one-cycle pulse at the start of each frame
underflow  out  1  sticky: the stream was starved in an active pixel
video_ifm  video_if.master  -  drives CLK, HS, VS, BLANK, RGB

Behaviour:
- HW = HDISP+HFP+HPULSE+HBP (928); VW = VDISP+VFP+VPULSE+VBP (525). Counter widths are $clog2(HW) and $clog2(VW).
- Line order is FP, pulse, BP, active. The same order applies to lines within a frame.
- h counts 0..HW-1 and wraps to 0. v increments when h==HW-1 and wraps from VW-1 to 0. v never reaches VW.
- active = (h >= HW-HDISP) && (v >= VW-VDISP). x = h-(HW-HDISP), y = v-(VW-VDISP).
- All video outputs are registered with 1-cycle latency: outputs after edge k reflect the counter state (h,v) held before edge k.
- HS = HS_POL when HFP <= h < HFP+HPULSE, else !HS_POL.
- VS = VS_POL when VFP <= v < VFP+VPULSE, else !VS_POL.
- BLANK = active (high means display the pixel).
- video_ifm.CLK = pixel_clk.
- Mode latch: mode is sampled into mode_q only when h==0 && v==0, so the source never changes mid-frame. mode_q resets to 0.
- frame_start is registered and asserted in the cycle after the counter state (0,0).
- Grid (mode 0): RGB = FFFFFF when x%GRID==0 or y%GRID==0, else 000000.
- Bars (mode 1): bar index = x*8/HDISP (0..7). Colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Solid (mode 3): RGB = solid_rgb, sampled each active cycle.
- Stream (mode 2):
  - pix_ready is combinational: active && mode_q==2.
  - A transfer occurs on valid&&ready, and pix_data is registered to RGB.
  - ready && !valid: RGB = 000000 for that pixel and underflow is set. The stream is not back-pressured.
  - underflow clears only on reset.
  - pix_ready is 0 in all other modes and during blanking.
- Outside active cycles RGB holds its last value.
- Reset values:
  - h=0, v=0
  - HS=!HS_POL, VS=!VS_POL, BLANK=0, RGB=0
  - frame_start=0, pix_ready=0, underflow=0
- Reset mid-frame returns the counters to (0,0) immediately. The first frame_start pulse follows release.

Decomposition:
- Package vga_pkg:
  - mode_t enum: MODE_GRID, MODE_BARS, MODE_STREAM, MODE_SOLID.
  - Bar colour constant array, localparam-style.
  - rgb_t as logic [23:0].
- Sub-module vga_timing: owns the h/v counters. Outputs h, v, active, hs_raw, vs_raw, sof.
- vga_gen owns pixel-source selection, the handshake, the output registers and underflow.

Test Plan:
- Release reset, default params -> HS low for exactly 48 cycles starting 41 cycles after release, with a line period of 928 cycles. frame_start period is 487200 cycles.
- Count lines with VS active -> VS low for exactly 3 lines (3*928 cycles). BLANK high for exactly 800 consecutive cycles on lines 45..524, and 384000 high cycles per frame.
- Mode 0 -> at x=0 and x=16 RGB=FFFFFF; at (x=1,y=1) RGB=000000. Mode 1 -> x=99 RGB=FFFFFF, x=100 RGB=FFFF00, x=799 RGB=000000.
- Mode 2, pix_valid always 1, pix_data = incrementing counter -> RGB sequence matches the consumed values with 1-cycle lag. Exactly 384000 transfers per frame, underflow stays 0.
- Mode 2, drop pix_valid for one active pixel -> RGB=000000 for that pixel, underflow=1 and stays 1. Change mode mid-frame -> output source changes only after the next frame_start.
- Set HS_POL=1, VS_POL=1 and assert reset mid-line -> HS/VS idle low, all outputs at reset values while reset is held. The counters restart at 0 on release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA generator: pixel colour, source
// selection and the colour-bar palette.
package vga_pkg;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    MODE_GRID   = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_STREAM = 2'd2,
    MODE_SOLID  = 2'd3
  } mode_t;

  localparam rgb_t RGB_WHITE = 24'hFFFFFF;
  localparam rgb_t RGB_BLACK = 24'h000000;

  // Left-to-right bar colours
  localparam rgb_t BAR_COLORS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/video_if.sv
// Display-side video bundle: pixel clock, syncs, blank and 24-bit RGB.
interface video_if;
  import vga_pkg::*;

  logic CLK;
  logic HS;
  logic VS;
  logic BLANK;
  rgb_t RGB;

  modport master (output CLK, HS, VS, BLANK, RGB);
  modport slave  (input  CLK, HS, VS, BLANK, RGB);
endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with raw sync, active-area and
// start-of-frame decodes. Line and frame order: front porch, pulse, back porch, active.
module vga_timing #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29,
  localparam int HW    = HDISP + HFP + HPULSE + HBP,
  localparam int VW    = VDISP + VFP + VPULSE + VBP,
  localparam int HBITS = $clog2(HW),
  localparam int VBITS = $clog2(VW)
) (
  input  logic             pixel_clk,
  input  logic             pixel_rst,
  output logic [HBITS-1:0] h,
  output logic [VBITS-1:0] v,
  output logic             active,
  output logic             hs_raw,
  output logic             vs_raw,
  output logic             sof
);

  localparam logic [HBITS-1:0] H_LAST   = HBITS'(HW - 1);
  localparam logic [VBITS-1:0] V_LAST   = VBITS'(VW - 1);
  localparam logic [HBITS-1:0] H_ACT    = HBITS'(HW - HDISP);
  localparam logic [VBITS-1:0] V_ACT    = VBITS'(VW - VDISP);
  localparam logic [HBITS-1:0] HS_START = HBITS'(HFP);
  localparam logic [HBITS-1:0] HS_END   = HBITS'(HFP + HPULSE);
  localparam logic [VBITS-1:0] VS_START = VBITS'(VFP);
  localparam logic [VBITS-1:0] VS_END   = VBITS'(VFP + VPULSE);

  logic [HBITS-1:0] h_reg;
  logic [VBITS-1:0] v_reg;

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      h_reg <= '0;
      v_reg <= '0;
    end else if (h_reg == H_LAST) begin
      h_reg <= '0;
      v_reg <= (v_reg == V_LAST) ? '0 : v_reg + 1'b1;
    end else begin
      h_reg <= h_reg + 1'b1;
    end
  end

  assign h      = h_reg;
  assign v      = v_reg;
  assign active = (h_reg >= H_ACT) && (v_reg >= V_ACT);
  assign hs_raw = (h_reg >= HS_START) && (h_reg < HS_END);
  assign vs_raw = (v_reg >= VS_START) && (v_reg < VS_END);
  assign sof    = (h_reg == '0) && (v_reg == '0);

endmodule

// File: rtl/vga_gen.sv
// VGA generator: selects one of four pixel sources per frame, runs the
// stream handshake and registers every display output one cycle after the raster position.
module vga_gen
  import vga_pkg::*;
#(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29,
  parameter int HS_POL = 0,
  parameter int VS_POL = 0,
  parameter int GRID   = 16
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        frame_start,
  output logic        underflow,
  video_if.master     video_ifm
);

  localparam int HW    = HDISP + HFP + HPULSE + HBP;
  localparam int VW    = VDISP + VFP + VPULSE + VBP;
  localparam int HBITS = $clog2(HW);
  localparam int VBITS = $clog2(VW);

  localparam logic [HBITS-1:0] X_ORG  = HBITS'(HW - HDISP);
  localparam logic [VBITS-1:0] Y_ORG  = VBITS'(VW - VDISP);
  localparam logic [HBITS-1:0] X_MASK = HBITS'(GRID - 1);
  localparam logic [VBITS-1:0] Y_MASK = VBITS'(GRID - 1);
  localparam logic             HS_ACT = (HS_POL != 0);
  localparam logic             VS_ACT = (VS_POL != 0);

  logic [HBITS-1:0] h;
  logic [VBITS-1:0] v;
  logic             active;
  logic             hs_raw;
  logic             vs_raw;
  logic             sof;

  vga_timing #(
    .HDISP (HDISP), .VDISP (VDISP),
    .HFP   (HFP),   .HPULSE(HPULSE), .HBP(HBP),
    .VFP   (VFP),   .VPULSE(VPULSE), .VBP(VBP)
  ) u_timing (
    .pixel_clk(pixel_clk),
    .pixel_rst(pixel_rst),
    .h        (h),
    .v        (v),
    .active   (active),
    .hs_raw   (hs_raw),
    .vs_raw   (vs_raw),
    .sof      (sof)
  );

  mode_t            mode_q;
  logic             hs_reg;
  logic             vs_reg;
  logic             blank_reg;
  rgb_t             rgb_reg;
  logic             frame_start_reg;
  logic             underflow_reg;
  rgb_t             rgb_next;
  logic [HBITS-1:0] x;
  logic [VBITS-1:0] y;
  logic             grid_on;
  logic [6:0]       bar_thermo;
  logic [2:0]       bar_idx;

  assign x       = h - X_ORG;
  assign y       = v - Y_ORG;
  assign grid_on = ((x & X_MASK) == '0) || ((y & Y_MASK) == '0);

  // Bar k starts at the first x with x*8/HDISP >= k, i.e. ceil(k*HDISP/8),
  // so the bar index is a thermometer count and needs no divider.
  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_bar_thr
      localparam int THR = (gi * HDISP + 7) / 8;
      assign bar_thermo[gi-1] = (x >= HBITS'(THR));
    end
  endgenerate

  always_comb begin
    bar_idx = '0;
    for (int i = 0; i < 7; i++) begin
      bar_idx = bar_idx + 3'(bar_thermo[i]);
    end
  end

  assign pix_ready = active && (mode_q == MODE_STREAM);

  always_comb begin
    rgb_next = RGB_BLACK;
    case (mode_q)
      MODE_GRID:   rgb_next = grid_on ? RGB_WHITE : RGB_BLACK;
      MODE_BARS:   rgb_next = BAR_COLORS[bar_idx];
      MODE_STREAM: rgb_next = pix_valid ? pix_data : RGB_BLACK;
      MODE_SOLID:  rgb_next = solid_rgb;
      default:     rgb_next = RGB_BLACK;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      mode_q          <= MODE_GRID;
      hs_reg          <= ~HS_ACT;
      vs_reg          <= ~VS_ACT;
      blank_reg       <= 1'b0;
      rgb_reg         <= RGB_BLACK;
      frame_start_reg <= 1'b0;
      underflow_reg   <= 1'b0;
    end else begin
      hs_reg          <= hs_raw ? HS_ACT : ~HS_ACT;
      vs_reg          <= vs_raw ? VS_ACT : ~VS_ACT;
      blank_reg       <= active;
      frame_start_reg <= sof;
      // Source is only switched at (0,0) so a frame never mixes sources
      if (sof) begin
        mode_q <= mode_t'(mode);
      end
      if (active) begin
        rgb_reg <= rgb_next;
      end
      if (pix_ready && !pix_valid) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign frame_start     = frame_start_reg;
  assign underflow       = underflow_reg;
  assign video_ifm.CLK   = pixel_clk;
  assign video_ifm.HS    = hs_reg;
  assign video_ifm.VS    = vs_reg;
  assign video_ifm.BLANK = blank_reg;
  assign video_ifm.RGB   = rgb_reg;

endmodule

// File: tb/tb_vga_gen.sv
// Bench for vga_gen: two instances (sync active-low and active-high) on a small
// raster, driven with random stimulus and compared against a raster-position model.
module tb_vga_gen;

  localparam int HDISP  = 36;
  localparam int VDISP  = 12;
  localparam int HFP    = 4;
  localparam int HPULSE = 5;
  localparam int HBP    = 3;
  localparam int VFP    = 2;
  localparam int VPULSE = 2;
  localparam int VBP    = 3;
  localparam int GRID   = 4;
  localparam int HW     = HDISP + HFP + HPULSE + HBP;
  localparam int VW     = VDISP + VFP + VPULSE + VBP;
  localparam int FW     = HW * VW;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst = 1'b0;
  logic [1:0]  mode      = 2'd0;
  logic [23:0] solid_rgb = '0;
  logic [23:0] pix_data  = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready0, pix_ready1;
  logic        frame_start0, frame_start1;
  logic        underflow0, underflow1;

  video_if vif0 ();
  video_if vif1 ();

  always #5 pixel_clk = ~pixel_clk;

  vga_gen #(
    .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .HS_POL(0), .VS_POL(0), .GRID(GRID)
  ) dut0 (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .mode(mode),
    .solid_rgb(solid_rgb), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready0), .frame_start(frame_start0), .underflow(underflow0),
    .video_ifm(vif0)
  );

  vga_gen #(
    .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .HS_POL(1), .VS_POL(1), .GRID(GRID)
  ) dut1 (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .mode(mode),
    .solid_rgb(solid_rgb), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready1), .frame_start(frame_start1), .underflow(underflow1),
    .video_ifm(vif1)
  );

  // Reference model state
  int          k;            // edges since reset release
  logic [1:0]  mode_frame;   // source in force for the current frame
  logic [23:0] rgb_m;
  logic        uf_m;
  bit          xfer;
  int          transfers;
  int          vectors;
  int          miscompares;
  logic [23:0] bars_tb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [1:0]  mode_list [3] = '{2'd0, 2'd1, 2'd3};
  logic [23:0] cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs0();
    return {3'b0, vif0.HS, vif0.VS, vif0.BLANK, vif0.RGB, frame_start0, underflow0};
  endfunction

  function automatic logic [31:0] obs1();
    return {3'b0, vif1.HS, vif1.VS, vif1.BLANK, vif1.RGB, frame_start1, underflow1};
  endfunction

  // Expected output bundle for raster position n of a frame
  function automatic logic [31:0] exp_out(input logic pol, input int n);
    int  h, v;
    logic hs_on, vs_on, act;
    h     = n % HW;
    v     = n / HW;
    hs_on = (h >= HFP) && (h < HFP + HPULSE);
    vs_on = (v >= VFP) && (v < VFP + VPULSE);
    act   = (h >= HW - HDISP) && (v >= VW - VDISP);
    return {3'b0, hs_on ? pol : ~pol, vs_on ? pol : ~pol, act, rgb_m, logic'(n == 0), uf_m};
  endfunction

  function automatic logic [31:0] exp_reset(input logic pol);
    return {3'b0, ~pol, ~pol, 1'b0, 24'h0, 1'b0, 1'b0};
  endfunction

  // Called at posedge+1 with inputs already driven; consumes one clock edge
  task automatic step();
    int   n, h, v, x, y;
    logic act, rdy;
    n   = k % FW;
    h   = n % HW;
    v   = n / HW;
    act = (h >= HW - HDISP) && (v >= VW - VDISP);
    x   = h - (HW - HDISP);
    y   = v - (VW - VDISP);
    #1;
    rdy = act && (mode_frame == 2'd2);
    check("pix_ready0", 32'(pix_ready0), 32'(rdy));
    check("pix_ready1", 32'(pix_ready1), 32'(rdy));
    xfer = rdy && pix_valid;
    if (xfer) transfers++;
    if (n == 0) mode_frame = mode;
    if (act) begin
      case (mode_frame)
        2'd0: rgb_m = ((x % GRID == 0) || (y % GRID == 0)) ? 24'hFFFFFF : 24'h000000;
        2'd1: rgb_m = bars_tb[(x * 8) / HDISP];
        2'd2: begin
          rgb_m = pix_valid ? pix_data : 24'h000000;
          if (!pix_valid) uf_m = 1'b1;
        end
        default: rgb_m = solid_rgb;
      endcase
    end
    @(posedge pixel_clk);
    #1;
    check("dut0 video", obs0(), exp_out(1'b0, n));
    check("dut1 video", obs1(), exp_out(1'b1, n));
    k++;
  endtask

  // Asserts reset at once, checks reset values while held, releases at posedge+1
  task automatic do_reset(input int cycles);
    pixel_rst = 1'b1;
    #1;
    check("reset dut0", obs0(), exp_reset(1'b0));
    check("reset dut1", obs1(), exp_reset(1'b1));
    repeat (cycles) begin
      @(posedge pixel_clk);
      #1;
      check("reset dut0", obs0(), exp_reset(1'b0));
      check("reset dut1", obs1(), exp_reset(1'b1));
      check("reset ready", {30'b0, pix_ready0, pix_ready1}, 32'h0);
    end
    pixel_rst  = 1'b0;
    k          = 0;
    mode_frame = 2'd0;
    rgb_m      = 24'h0;
    uf_m       = 1'b0;
  endtask

  task automatic randomize_inputs(input bit churn_mode);
    solid_rgb = 24'($urandom);
    pix_data  = 24'($urandom);
    pix_valid = ($urandom_range(0, 7) != 0);
    if (churn_mode && $urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    transfers   = 0;
    #1;
    do_reset(3);

    // One full frame each of grid, bars and solid
    foreach (mode_list[i]) begin
      mode = mode_list[i];
      repeat (FW) begin
        randomize_inputs(1'b0);
        step();
      end
    end

    // Stream with valid always high and incrementing data
    mode      = 2'd2;
    transfers = 0;
    cnt       = '0;
    repeat (FW) begin
      pix_valid = 1'b1;
      pix_data  = cnt;
      solid_rgb = 24'($urandom);
      step();
      if (xfer) cnt++;
    end
    check("transfers per frame", 32'(transfers), 32'(HDISP * VDISP));
    check("underflow clean", 32'(underflow0), 32'd0);

    // Stream with occasional starvation
    repeat (FW) begin
      randomize_inputs(1'b0);
      step();
    end
    check("underflow sticky", 32'(underflow0), 32'd1);

    // Mode changes at arbitrary points in the frame
    repeat (2 * FW) begin
      randomize_inputs(1'b1);
      step();
    end

    // Reset in the middle of a line, then run on
    repeat (FW / 2 + 7) begin
      randomize_inputs(1'b1);
      step();
    end
    do_reset(3);
    repeat (FW + 60) begin
      randomize_inputs(1'b1);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
